cp0_exc_ctrl: RTL

// Coprocessor-0 exception/interrupt controller for the P7 pipelined MIPS core. Sits beside the
// M stage, samples the M-stage instruction's PC, branch-delay flag and exception code, and

---
 rtl/cp0_exc_ctrl_if.sv | 30 +++
 rtl/cp0_exc_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage to CP0 bundle: mfc0/mtc0 access, exception sampling, flush request.
// The pipeline drives through master; the CP0 block answers through slave.
interface cp0_exc_ctrl_if #(
    parameter int NUM_HWINT = 6
);
    logic                 en;
    logic [4:0]           cp0_addr;
    logic [31:0]          cp0_wdata;
    logic [31:0]          pc_M;
    logic                 bd_M;
    logic [4:0]           exc_code_M;
    logic                 eret_M;
    logic [NUM_HWINT-1:0] hw_int;
    logic [31:0]          cp0_rdata;
    logic [31:0]          epc_out;
    logic [31:0]          handler_pc;
    logic                 req;

    modport master (
        output en, cp0_addr, cp0_wdata, pc_M, bd_M,
        output exc_code_M, eret_M, hw_int,
        input  cp0_rdata, epc_out, handler_pc, req
    );

    modport slave (
        input  en, cp0_addr, cp0_wdata, pc_M, bd_M,
        input  exc_code_M, eret_M, hw_int,
        output cp0_rdata, epc_out, handler_pc, req
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage.
// Holds SR/Cause/EPC, decides the flush request, serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          NUM_HWINT    = 6
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_ctrl_if.slave  bus
);
    logic [NUM_HWINT-1:0] im;
    logic                 exl;
    logic                 ie;
    logic                 bd;
    logic [NUM_HWINT-1:0] ip;
    logic [4:0]           exc_code;
    logic [31:0]          epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] epc_exc;
    logic [31:0] wdata_epc;
    logic [31:0] sr;
    logic [31:0] cause;

    // Interrupts look at the live lines so a freshly raised level is taken this cycle.
    assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req = (bus.exc_code_M != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign epc_exc   = (bus.bd_M ? bus.pc_M - 32'd4 : bus.pc_M) & 32'hFFFF_FFFC;
    assign wdata_epc = {bus.cp0_wdata[31:2], 2'b00};

    assign sr    = {16'd0, im, 8'd0, exl, ie};
    assign cause = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= bus.hw_int;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bus.bd_M;
                epc      <= epc_exc;
                exc_code <= int_req ? 5'd0 : bus.exc_code_M;
            end else begin
                if (bus.en && bus.cp0_addr == 5'd12) begin
                    im  <= bus.cp0_wdata[15:10];
                    exl <= bus.cp0_wdata[1];
                    ie  <= bus.cp0_wdata[0];
                end
                if (bus.en && bus.cp0_addr == 5'd14)
                    epc <= wdata_epc;
                // Returning from the handler takes precedence over a same-cycle SR write.
                if (bus.eret_M)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            5'd12:   bus.cp0_rdata = sr;
            5'd13:   bus.cp0_rdata = cause;
            5'd14:   bus.cp0_rdata = epc;
            default: bus.cp0_rdata = 32'd0;
        endcase
    end

    // Forward an in-flight EPC write so mtc0 followed by eret returns to the new target.
    assign bus.epc_out    = (bus.en && bus.cp0_addr == 5'd14) ? wdata_epc : epc;
    assign bus.handler_pc = HANDLER_ADDR;
    assign bus.req        = req;
endmodule
